// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared IO constants for the SPI target
package spi_target_pkg;
    localparam int FRAME_W = 8;
    localparam int CNT_W   = 3;
    localparam logic [FRAME_W-1:0] IDLE_BYTE_DEFAULT = 8'hFF;
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(FRAME_W - 1);
endpackage

// File: rtl/spi_target_syncbit.sv
// rtl/spi_target_syncbit.sv - multi-stage synchronizer for one asynchronous input bit
module syncbit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetq,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode 0 target with one-byte transmit holding register
module spi_target
    import spi_target_pkg::*;
#(
    parameter int                 SYNC_STAGES = 2,
    parameter logic [FRAME_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
    input  logic               clk,
    input  logic               resetq,
    input  logic               sck,
    input  logic               mosi,
    input  logic               cs_n,
    output logic               miso,
    output logic               miso_oe,
    input  logic               rd,
    input  logic               wr,
    input  logic [FRAME_W-1:0] tx_data,
    output logic [FRAME_W-1:0] rx_data,
    output logic               valid,
    output logic               busy,
    output logic               overrun
);
    logic sck_s, mosi_s, cs_s;
    logic sck_q, cs_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] rx_shift;
    logic [FRAME_W-1:0] tx_shift;
    logic [FRAME_W-1:0] hold;
    logic               reload_due;

    syncbit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .resetq(resetq), .d(sck),  .q(sck_s));
    syncbit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .resetq(resetq), .d(mosi), .q(mosi_s));
    syncbit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .resetq(resetq), .d(cs_n), .q(cs_s));

    // Edges only count while the synchronized chip select is active.
    logic sck_rise, sck_fall, cs_fall, load;
    logic [FRAME_W-1:0] rx_next;
    assign sck_rise = !cs_s && sck_s && !sck_q;
    assign sck_fall = !cs_s && !sck_s && sck_q;
    assign cs_fall  = cs_q && !cs_s;
    assign load     = cs_fall || (sck_fall && reload_due);
    assign rx_next  = {rx_shift, mosi_s};

    assign miso    = tx_shift[FRAME_W-1];
    assign miso_oe = !cs_s;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            hold       <= '0;
            rx_data    <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            reload_due <= 1'b0;
        end else begin
            sck_q <= sck_s;
            cs_q  <= cs_s;

            if (rd) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end

            if (wr && !busy) begin
                hold <= tx_data;
                busy <= 1'b1;
            end

            // Deselect drops any partial byte but leaves the holding register alone.
            if (cs_s) begin
                bit_cnt    <= '0;
                reload_due <= 1'b0;
            end else if (sck_rise) begin
                rx_shift <= rx_next[FRAME_W-2:0];
                bit_cnt  <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    rx_data    <= rx_next;
                    valid      <= 1'b1;
                    reload_due <= 1'b1;
                    if (valid && !rd) begin
                        overrun <= 1'b1;
                    end
                end
            end

            // A write landing on a load with busy=0 stays pending for the next byte.
            if (load) begin
                reload_due <= 1'b0;
                if (busy) begin
                    tx_shift <= hold;
                    busy     <= 1'b0;
                end else begin
                    tx_shift <= IDLE_BYTE;
                end
            end else if (sck_fall) begin
                tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - self-checking bench for spi_target with an rx scoreboard
module tb_spi_target;
    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, valid, busy, overrun;
    logic [7:0] rx_data;

    spi_target #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .resetq(resetq), .sck(sck), .mosi(mosi), .cs_n(cs_n),
        .miso(miso), .miso_oe(miso_oe), .rd(rd), .wr(wr), .tx_data(tx_data),
        .rx_data(rx_data), .valid(valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_rx_q[$];
    logic       model_busy = 1'b0;
    logic [7:0] model_hold = 8'h00;
    logic [7:0] exp_tx_cur = 8'hFF;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [7:0] d);
        tx_data = d;
        wr = 1'b1;
        tick(1);
        wr = 1'b0;
        if (!model_busy) begin
            model_busy = 1'b1;
            model_hold = d;
        end
    endtask

    task automatic do_rd();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    function automatic logic [7:0] next_tx();
        logic [7:0] b;
        b = model_busy ? model_hold : 8'hFF;
        model_busy = 1'b0;
        return b;
    endfunction

    task automatic cs_low();
        cs_n = 1'b0;
        exp_tx_cur = next_tx();
        tick(HALF);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        tick(HALF);
    endtask

    // Shift nbits of mo MSB first; a full byte is scored against rx and miso expectations.
    task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit chk_lat);
        logic [7:0] got;
        got = 8'h00;
        if (nbits == 8) exp_rx_q.push_back(mo);
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = mo[i];
            tick(HALF);
            got[i] = miso;
            sck = 1'b1;
            if (i == 0 && chk_lat) begin
                tick(SYNC);
                check("valid_before_sync", {7'd0, valid}, 8'd0);
                tick(1);
                check("valid_latency", {7'd0, valid}, 8'd1);
                tick(HALF - SYNC - 1);
            end else begin
                tick(HALF);
            end
            sck = 1'b0;
        end
        if (nbits == 8) begin
            check("miso_byte", got, exp_tx_cur);
            exp_tx_cur = next_tx();
            tick(HALF);
            check("rx_data", rx_data, exp_rx_q.pop_front());
        end
    endtask

    initial begin
        tick(2);
        check("rst_miso", {7'd0, miso}, 8'd0);
        check("rst_miso_oe", {7'd0, miso_oe}, 8'd0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_flags", {5'd0, valid, busy, overrun}, 8'd0);
        resetq = 1'b1;
        tick(2);

        // Written byte goes out, received byte lands.
        do_wr(8'hA5);
        check("busy_after_wr", {7'd0, busy}, 8'd1);
        cs_low();
        check("miso_oe_active", {7'd0, miso_oe}, 8'd1);
        spi_byte(8'h3C, 8, 1'b1);
        check("valid_t1", {7'd0, valid}, 8'd1);
        check("busy_t1", {7'd0, busy}, 8'd0);
        cs_high();
        check("miso_oe_idle", {7'd0, miso_oe}, 8'd0);
        do_rd();

        // Idle byte when nothing written; rd clears valid one clk later.
        cs_low();
        spi_byte(8'hC3, 8, 1'b0);
        cs_high();
        rd = 1'b1;
        #1;
        check("valid_before_rd_edge", {7'd0, valid}, 8'd1);
        tick(1);
        rd = 1'b0;
        check("valid_after_rd", {7'd0, valid}, 8'd0);

        // Back-to-back bytes without rd produce overrun.
        cs_low();
        spi_byte(8'h01, 8, 1'b0);
        check("overrun_first", {7'd0, overrun}, 8'd0);
        spi_byte(8'h02, 8, 1'b0);
        check("overrun_set", {7'd0, overrun}, 8'd1);
        cs_high();
        do_rd();
        check("valid_cleared", {7'd0, valid}, 8'd0);
        check("overrun_cleared", {7'd0, overrun}, 8'd0);

        // Partial byte discarded, next frame aligns from bit 0.
        cs_low();
        spi_byte(8'hF0, 5, 1'b0);
        cs_high();
        check("partial_no_valid", {7'd0, valid}, 8'd0);
        cs_low();
        spi_byte(8'h81, 8, 1'b0);
        cs_high();
        do_rd();

        // Second write while busy is ignored.
        do_wr(8'h11);
        do_wr(8'h22);
        cs_low();
        spi_byte(8'h00, 8, 1'b0);
        cs_high();

        // Reset mid-frame forces outputs immediately.
        do_wr(8'h77);
        cs_low();
        spi_byte(8'hFF, 4, 1'b0);
        resetq = 1'b0;
        #2;
        check("midrst_miso", {7'd0, miso}, 8'd0);
        check("midrst_miso_oe", {7'd0, miso_oe}, 8'd0);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_flags", {5'd0, valid, busy, overrun}, 8'd0);
        cs_n = 1'b1;
        model_busy = 1'b0;
        tick(2);
        resetq = 1'b1;
        tick(2);
        cs_low();
        spi_byte(8'h5A, 8, 1'b0);
        cs_high();
        check("final_valid", {7'd0, valid}, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
